// File: rtl/shot_scheduler.sv
// Shot table sequencer: per-frame off-screen cleanup scan, hit/scan delete arbitration, fire rate limiting.
// Optional statistics counters are enabled by defining SHOT_STATS_EN.
module shot_scheduler #(
  parameter int SHOT_COUNT  = 10,
  parameter int ENTITY_SIZE = 34,
  parameter int COOLDOWN    = 8,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  localparam int AW         = $clog2(SHOT_COUNT)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              frame_tick,
  input  logic                              fire_btn,
  input  logic [SHOT_COUNT*ENTITY_SIZE-1:0] shots_data,
  input  logic                              hit_req,
  input  logic [AW-1:0]                     hit_addr,
  output logic                              hit_ack,
  output logic                              shoot,
  output logic                              delete_shot,
  output logic [AW-1:0]                     shot_address,
  output logic                              move_en,
  output logic                              busy,
`ifdef SHOT_STATS_EN
  output logic [15:0]                       fired_cnt,
  output logic [15:0]                       deleted_cnt,
  output logic [15:0]                       dropped_cnt,
`endif
  output logic                              overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, MOVE} state_t;

  localparam logic [AW-1:0] LAST_IDX  = AW'(SHOT_COUNT - 1);
  localparam logic [7:0]    COOL_LOAD = 8'(COOLDOWN);

  state_t          state_reg, state_next;
  logic [AW-1:0]   idx_reg, idx_next;
  logic [7:0]      cooldown_reg;
  logic            fire_pend_reg;
  logic            sync_meta_reg, sync_reg, sync_prev_reg;
  logic            overrun_reg;
  logic            fire_clear, drop_shot;
  logic            fire_rise;
  logic [SHOT_COUNT-1:0] active_vec, gone_vec;

  for (genvar gi = 0; gi < SHOT_COUNT; gi++) begin : g_slot
    logic [ENTITY_SIZE-1:0] slot;
    logic [9:0]             pos_x, pos_y;
    logic                   slot_unused;
    assign slot           = shots_data[gi*ENTITY_SIZE +: ENTITY_SIZE];
    assign pos_x          = slot[15:6];
    assign pos_y          = slot[25:16];
    assign slot_unused    = ^{slot[32:26], slot[5:0]};
    assign active_vec[gi] = slot[33];
    // Unsigned compare: a coordinate decremented past 0 wraps high and counts as off-screen.
    assign gone_vec[gi]   = slot[33] && ((pos_x > 10'(X_MAX)) || (pos_y > 10'(Y_MAX)));
  end

  assign fire_rise = sync_reg & ~sync_prev_reg;
  assign busy      = (state_reg != IDLE);
  assign overrun   = overrun_reg;

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    hit_ack      = 1'b0;
    delete_shot  = 1'b0;
    shot_address = '0;
    shoot        = 1'b0;
    move_en      = 1'b0;
    fire_clear   = 1'b0;
    drop_shot    = 1'b0;
    if (hit_req && state_reg != SCAN) begin
      hit_ack      = 1'b1;
      delete_shot  = 1'b1;
      shot_address = hit_addr;
    end
    case (state_reg)
      IDLE: begin
        if (frame_tick) begin
          state_next = SCAN;
          idx_next   = '0;
        end else if (fire_pend_reg && !hit_req) begin
          if (cooldown_reg == 8'd0 && !(&active_vec)) begin
            shoot      = 1'b1;
            fire_clear = 1'b1;
          end else if (&active_vec) begin
            fire_clear = 1'b1;
            drop_shot  = 1'b1;
          end
        end
      end
      SCAN: begin
        // A collision delete steals the port; the scan index waits for the next cycle.
        if (hit_req) begin
          hit_ack      = 1'b1;
          delete_shot  = 1'b1;
          shot_address = hit_addr;
        end else begin
          if (gone_vec[idx_reg]) begin
            delete_shot  = 1'b1;
            shot_address = idx_reg;
          end
          if (idx_reg == LAST_IDX) begin
            state_next = MOVE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      MOVE: begin
        move_en    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      cooldown_reg  <= 8'd0;
      fire_pend_reg <= 1'b0;
      sync_meta_reg <= 1'b0;
      sync_reg      <= 1'b0;
      sync_prev_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      sync_meta_reg <= fire_btn;
      sync_reg      <= sync_meta_reg;
      sync_prev_reg <= sync_reg;
      if (fire_rise) begin
        fire_pend_reg <= 1'b1;
      end else if (fire_clear) begin
        fire_pend_reg <= 1'b0;
      end
      if (shoot) begin
        cooldown_reg <= COOL_LOAD;
      end else if (frame_tick && cooldown_reg != 8'd0) begin
        cooldown_reg <= cooldown_reg - 8'd1;
      end
      if (frame_tick && state_reg != IDLE) begin
        overrun_reg <= 1'b1;
      end
    end
  end

`ifdef SHOT_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fired_cnt   <= 16'd0;
      deleted_cnt <= 16'd0;
      dropped_cnt <= 16'd0;
    end else begin
      if (shoot && fired_cnt != 16'hFFFF)          fired_cnt   <= fired_cnt + 16'd1;
      if (delete_shot && deleted_cnt != 16'hFFFF)  deleted_cnt <= deleted_cnt + 16'd1;
      if (drop_shot && dropped_cnt != 16'hFFFF)    dropped_cnt <= dropped_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shot_scheduler.sv
// Scoreboard bench for shot_scheduler: a transaction-level model predicts shoot/delete/move events
// with their cycle numbers; a negedge monitor pops and compares them as the DUT produces them.
module tb_shot_scheduler;
  localparam int SC = 10;
  localparam int ES = 34;
  localparam int CD = 8;
  localparam int XM = 639;
  localparam int YM = 479;
  localparam int AW = 4;
  localparam int K_SHOOT = 0;
  localparam int K_DEL   = 1;
  localparam int K_MOVE  = 2;

  logic              clk = 1'b0;
  logic              reset_n, frame_tick, fire_btn, hit_req;
  logic [AW-1:0]     hit_addr;
  logic [SC*ES-1:0]  shots_data;
  logic              hit_ack, shoot, delete_shot, move_en, busy, overrun;
  logic [AW-1:0]     shot_address;
`ifdef SHOT_STATS_EN
  logic [15:0]       fired_cnt, deleted_cnt, dropped_cnt;
`endif

  shot_scheduler dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .fire_btn(fire_btn),
    .shots_data(shots_data), .hit_req(hit_req), .hit_addr(hit_addr), .hit_ack(hit_ack),
    .shoot(shoot), .delete_shot(delete_shot), .shot_address(shot_address),
    .move_en(move_en), .busy(busy),
`ifdef SHOT_STATS_EN
    .fired_cnt(fired_cnt), .deleted_cnt(deleted_cnt), .dropped_cnt(dropped_cnt),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    int kind;
    int addr;
    int hit;
    int cyc;
  } ev_t;
  ev_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit act[SC];
  int tx[SC];
  int ty[SC];
  int cd_m = 0;
  int pend_m = 0;
  int fired_m = 0, deleted_m = 0, dropped_m = 0;

  function automatic bit gone(int k);
    return act[k] && (tx[k] > XM || ty[k] > YM);
  endfunction

  function automatic bit table_full();
    for (int k = 0; k < SC; k++) if (!act[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [SC*ES-1:0] pack_table();
    logic [SC*ES-1:0] v;
    v = '0;
    for (int k = 0; k < SC; k++) begin
      v[k*ES+33]      = act[k];
      v[k*ES+16 +: 10] = 10'(ty[k]);
      v[k*ES+6 +: 10]  = 10'(tx[k]);
    end
    return v;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int addr, input int hit, input int t);
    ev_t e;
    e.kind = kind; e.addr = addr; e.hit = hit; e.cyc = t;
    sb.push_back(e);
    if (kind == K_DEL) deleted_m++;
    if (kind == K_SHOOT) fired_m++;
  endtask

  // Decision taken whenever the scheduler sits idle with a pending fire request.
  task automatic idle_eval(input int t);
    if (pend_m != 0) begin
      if (cd_m == 0 && !table_full()) begin
        push_ev(K_SHOOT, 0, 0, t);
        cd_m = CD;
        pend_m = 0;
      end else if (table_full()) begin
        pend_m = 0;
        dropped_m++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_table();
    shots_data = pack_table();
    idle_eval(cyc);
  endtask

  task automatic rand_table(input int p_active);
    for (int k = 0; k < SC; k++) begin
      int sel;
      act[k] = ($urandom_range(0, 99) < p_active);
      sel = $urandom_range(0, 3);
      tx[k] = $urandom_range(0, XM);
      ty[k] = $urandom_range(0, YM);
      if (sel == 0) tx[k] = $urandom_range(XM + 1, 1023);
      if (sel == 1) ty[k] = $urandom_range(YM + 1, 1023);
    end
  endtask

  task automatic onscreen_table(input bit active);
    for (int k = 0; k < SC; k++) begin
      act[k] = active;
      tx[k] = $urandom_range(0, XM);
      ty[k] = $urandom_range(0, YM);
    end
  endtask

  // Synchroniser plus edge detector put the shoot decision three cycles after the press.
  task automatic press();
    fire_btn = 1'b1;
    pend_m = 1;
    idle_eval(cyc + 3);
    step();
    step();
    fire_btn = 1'b0;
    repeat (4) step();
  endtask

  // Push the events of one scan starting with a frame_tick in cycle c; returns the move_en cycle.
  task automatic predict_frame(input int c, input int hs, input int ha, output int tmove);
    int t;
    t = c + 1;
    for (int k = 0; k < SC; k++) begin
      if (k == hs) begin
        push_ev(K_DEL, ha, 1, t);
        t++;
      end
      if (gone(k)) push_ev(K_DEL, k, 0, t);
      t++;
    end
    push_ev(K_MOVE, 0, 0, t);
    tmove = t;
    idle_eval(t + 1);
  endtask

  task automatic run_frame(input int hs, input int ha);
    int c, tmove;
    c = cyc;
    frame_tick = 1'b1;
    if (cd_m > 0) cd_m--;
    predict_frame(c, hs, ha, tmove);
    step();
    frame_tick = 1'b0;
    check("busy_in_scan", int'(busy), 1);
    if (hs >= 0) begin
      while (cyc < c + 1 + hs) step();
      hit_req = 1'b1;
      hit_addr = AW'(ha);
      step();
      hit_req = 1'b0;
    end
    while (cyc < tmove + 2) step();
    check("busy_after_frame", int'(busy), 0);
  endtask

  task automatic idle_hit(input int a);
    hit_req = 1'b1;
    hit_addr = AW'(a);
    push_ev(K_DEL, a, 1, cyc);
    step();
    hit_req = 1'b0;
    step();
  endtask

  // Monitor: compares every output pulse with the head of the scoreboard.
  task automatic mon_event(input int kind, input int addr, input int hit);
    ev_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL event: got kind=%0d addr=%0d hit=%0d at cycle %0d, expected no event",
               kind, addr, hit, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.addr != addr || e.hit != hit || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got kind=%0d addr=%0d hit=%0d cycle=%0d, expected kind=%0d addr=%0d hit=%0d cycle=%0d",
                 kind, addr, hit, cyc, e.kind, e.addr, e.hit, e.cyc);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (shoot) mon_event(K_SHOOT, 0, 0);
    if (delete_shot) mon_event(K_DEL, int'(shot_address), int'(hit_ack));
    if (move_en) mon_event(K_MOVE, 0, 0);
    if ((!delete_shot && shot_address != '0) || (hit_ack && !delete_shot) || (shoot && delete_shot)) begin
      n_checks++;
      n_fail++;
      $display("FAIL output_rules: shoot=%0b delete_shot=%0b hit_ack=%0b shot_address=%0d at cycle %0d",
               shoot, delete_shot, hit_ack, shot_address, cyc);
    end
  end

  initial begin
    int c, tmove;
    reset_n = 1'b0;
    frame_tick = 1'b0;
    fire_btn = 1'b0;
    hit_req = 1'b0;
    hit_addr = '0;
    onscreen_table(1'b0);
    shots_data = pack_table();

    // Reset with toggling inputs: every output stays low.
    for (int i = 0; i < 6; i++) begin
      step();
      frame_tick = (i % 2 == 0);
      fire_btn = (i % 2 == 1);
      @(negedge clk);
      check("reset_outputs", int'({hit_ack, shoot, delete_shot, shot_address, move_en, busy, overrun}), 0);
    end
    step();
    frame_tick = 1'b0;
    fire_btn = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    step();
    check("busy_after_reset", int'(busy), 0);
    check("overrun_after_reset", int'(overrun), 0);

    // Fire rate limiting with an empty table.
    for (int f = 0; f < 12; f++) begin
      if (f < 3 || f == 10) press();
      run_frame(-1, 0);
    end

    // Scan deletes: slot 3 off in x, slot 5 off in y.
    onscreen_table(1'b1);
    tx[3] = 700;
    ty[5] = 480;
    set_table();
    run_frame(-1, 0);

    // Collision hit wins over the scan delete at idx 3.
    onscreen_table(1'b1);
    tx[3] = 1000;
    act[9] = 1'b0;
    set_table();
    run_frame(3, 7);

    // Full table: press is dropped, and nothing fires later from it.
    onscreen_table(1'b1);
    set_table();
    repeat (2) step();
    press();
    onscreen_table(1'b0);
    set_table();
    for (int f = 0; f < 9; f++) run_frame(-1, 0);

    // Randomised frames.
    for (int it = 0; it < 25; it++) begin
      int hs;
      rand_table($urandom_range(30, 100));
      set_table();
      step();
      if ($urandom_range(0, 1) == 1) press();
      if ($urandom_range(0, 3) == 0) idle_hit($urandom_range(0, SC - 1));
      hs = $urandom_range(0, 12);
      if (hs >= SC) hs = -1;
      run_frame(hs, $urandom_range(0, SC - 1));
    end

    // Overrun: a second frame_tick at scan idx 4 is ignored but latched.
    rand_table(80);
    set_table();
    step();
    c = cyc;
    frame_tick = 1'b1;
    if (cd_m > 0) cd_m--;
    if (cd_m > 0) cd_m--;
    predict_frame(c, -1, 0, tmove);
    step();
    frame_tick = 1'b0;
    while (cyc < c + 5) step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("overrun_set", int'(overrun), 1);
    check("busy_during_overrun", int'(busy), 1);
    while (cyc < tmove + 2) step();
    check("overrun_sticky", int'(overrun), 1);

    // Reset in the middle of a scan at idx 6: no further pulses.
    onscreen_table(1'b1);
    tx[2] = 800;
    ty[7] = 1023;
    set_table();
    step();
    c = cyc;
    frame_tick = 1'b1;
    push_ev(K_DEL, 2, 0, c + 3);
    step();
    frame_tick = 1'b0;
    while (cyc < c + 7) step();
    reset_n = 1'b0;
    cd_m = 0; pend_m = 0; fired_m = 0; deleted_m = 0; dropped_m = 0;
    repeat (3) step();
    check("mid_scan_reset_outputs", int'({hit_ack, shoot, delete_shot, shot_address, move_en, busy}), 0);
    check("mid_scan_reset_overrun", int'(overrun), 0);
    reset_n = 1'b1;
    repeat (14) step();
    check("idle_after_reset", int'(busy), 0);

    // Post-reset sanity: full table drop then one frame.
    onscreen_table(1'b1);
    set_table();
    step();
    press();
    run_frame(-1, 0);

    repeat (4) step();
    check("scoreboard_drained", sb.size(), 0);
`ifdef SHOT_STATS_EN
    check("fired_cnt", int'(fired_cnt), fired_m);
    check("deleted_cnt", int'(deleted_cnt), deleted_m);
    check("dropped_cnt", int'(dropped_cnt), dropped_m);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
